// File: rtl/dem_pn_sequence_gen.sv
// Galois-LFSR PN bit source for the DEM switching tree: NUM_PN bits per advance,
// reseed handshake and all-zero lockup recovery. Define DEM_PN_CHOP_EN for polarity chopping.
module dem_pn_sequence_gen #(
  parameter int unsigned           LFSR_WIDTH   = 16,
  parameter int unsigned           NUM_PN       = 8,
  parameter logic [LFSR_WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = 16'h0001
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  enable_i,
  input  logic                  seed_load_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  output logic                  seed_ack_o,
  output logic [NUM_PN-1:0]     pn_seq_o,
  output logic                  pn_valid_o,
  output logic                  lockup_o
);

  typedef enum logic [1:0] {IDLE, RUN, SEED, RECOVER} state_e;

  state_e                  state_q, state_d;
  logic [LFSR_WIDTH-1:0]   lfsr, lfsr_d;
  logic [LFSR_WIDTH-1:0]   lfsr_next_p0;
  logic [NUM_PN-1:0]       raw_bits_p0, pn_bits_p0;
  logic                    adv_p0, load_p0, lockup_det_p0;

  // NUM_PN chained right-shift Galois steps; bit j is the output of step j.
  function automatic logic [LFSR_WIDTH+NUM_PN-1:0] advance(input logic [LFSR_WIDTH-1:0] s);
    logic [LFSR_WIDTH-1:0] st;
    logic [NUM_PN-1:0]     bits;
    st   = s;
    bits = '0;
    for (int j = 0; j < int'(NUM_PN); j++) begin
      bits[j] = st[0];
      st      = (st >> 1) ^ (st[0] ? TAPS : '0);
    end
    return {st, bits};
  endfunction

  assign {lfsr_next_p0, raw_bits_p0} = advance(lfsr);

  // A zero state is only tolerated during the RECOVER cycle that overwrites it.
  assign lockup_det_p0 = (lfsr == '0) && (state_q != RECOVER);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr;
    adv_p0  = 1'b0;
    load_p0 = 1'b0;
    if (state_q == RECOVER) begin
      state_d = IDLE;
      lfsr_d  = SEED_DEFAULT;
    end else if (lockup_det_p0) begin
      state_d = RECOVER;
    end else if (seed_load_i) begin
      state_d = SEED;
      load_p0 = 1'b1;
      lfsr_d  = (seed_i == '0) ? SEED_DEFAULT : seed_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            adv_p0  = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (enable_i) adv_p0 = 1'b1;
          else          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (adv_p0) lfsr_d = lfsr_next_p0;
  end

`ifdef DEM_PN_CHOP_EN
  logic phase_q;

  assign pn_bits_p0 = raw_bits_p0 ^ {NUM_PN{phase_q}};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                       phase_q <= 1'b0;
    else if (load_p0 || lockup_det_p0 || state_q == RECOVER) phase_q <= 1'b0;
    else if (adv_p0)                                     phase_q <= ~phase_q;
  end
`else
  assign pn_bits_p0 = raw_bits_p0;
`endif

  // ---- p0 -> p1: registered state and outputs ----
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      lfsr       <= SEED_DEFAULT;
      pn_seq_o   <= '0;
      pn_valid_o <= 1'b0;
      seed_ack_o <= 1'b0;
      lockup_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr       <= lfsr_d;
      pn_valid_o <= adv_p0;
      seed_ack_o <= load_p0;
      if (adv_p0)             pn_seq_o <= pn_bits_p0;
      if (lockup_det_p0)      lockup_o <= 1'b1;
      else if (load_p0)       lockup_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dem_pn_sequence_gen.sv
// Scoreboard bench for dem_pn_sequence_gen: directed cases then randomized traffic.
module tb_dem_pn_sequence_gen;

`ifdef DEM_PN_CHOP_EN
  localparam bit       CHOP = 1'b1;
  localparam bit [7:0] EXP2 = 8'h97;
`else
  localparam bit       CHOP = 1'b0;
  localparam bit [7:0] EXP2 = 8'h68;
`endif

  logic        clk_i       = 1'b0;
  logic        reset_ni    = 1'b0;
  logic        enable_i    = 1'b0;
  logic        seed_load_i = 1'b0;
  logic [15:0] seed_i      = '0;
  logic        seed_ack_o;
  logic [7:0]  pn_seq_o;
  logic        pn_valid_o;
  logic        lockup_o;

  always #5 clk_i = ~clk_i;

  dem_pn_sequence_gen dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .seed_ack_o  (seed_ack_o),
    .pn_seq_o    (pn_seq_o),
    .pn_valid_o  (pn_valid_o),
    .lockup_o    (lockup_o)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] ack_q[$];
  logic [15:0] m_lfsr    = 16'h0001;
  logic        m_phase   = 1'b0;
  logic        m_in_seed = 1'b0;
  logic [7:0]  last_pn   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: polynomial division step as integer arithmetic on the state value.
  function automatic logic [7:0] model_advance();
    int unsigned s = m_lfsr;
    logic [7:0]  bits;
    for (int j = 0; j < 8; j++) begin
      bits[j] = (s % 2) == 1;
      s = (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
    end
    m_lfsr = s[15:0];
    return bits;
  endfunction

  task automatic model_step(input logic en, input logic ld, input logic [15:0] sd);
    logic [7:0] b;
    if (ld) begin
      m_lfsr    = (sd == 16'h0) ? 16'h0001 : sd;
      m_phase   = 1'b0;
      m_in_seed = 1'b1;
      ack_q.push_back(m_lfsr);
    end else if (m_in_seed) begin
      m_in_seed = 1'b0;
    end else if (en) begin
      b = model_advance();
      exp_q.push_back(b ^ (CHOP ? {8{m_phase}} : 8'h00));
      m_phase = ~m_phase;
    end
  endtask

  task automatic cycle(input logic en, input logic ld, input logic [15:0] sd);
    @(negedge clk_i);
    enable_i    = en;
    seed_load_i = ld;
    seed_i      = sd;
    model_step(en, ld, sd);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents PN bits or a seed ack.
  initial begin
    logic [7:0]  e;
    logic [15:0] a;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        last_pn = '0;
      end else begin
        if (pn_valid_o) begin
          if (exp_q.size() == 0) chk("pn_unexpected_valid", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("pn_seq", pn_seq_o, e);
            last_pn = e;
          end
        end else begin
          chk("pn_hold", pn_seq_o, last_pn);
        end
        if (seed_ack_o) begin
          if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
          else begin
            a = ack_q.pop_front();
            chk("ack_lfsr", dut.lfsr, a);
            chk("ack_lockup_clr", lockup_o, 0);
          end
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_pn", pn_seq_o, 0);
    chk("rst_valid", pn_valid_o, 0);
    chk("rst_ack", seed_ack_o, 0);
    chk("rst_lockup", lockup_o, 0);
    chk("rst_lfsr", dut.lfsr, 16'h0001);
    @(posedge clk_i); #2 reset_ni = 1'b1;

    cycle(1, 0, 16'h0);
    @(posedge clk_i); #1;
    chk("adv1_pn", pn_seq_o, 8'h01);
    chk("adv1_valid", pn_valid_o, 1);
    chk("adv1_lfsr", dut.lfsr, 16'h0168);
    cycle(1, 0, 16'h0);
    @(posedge clk_i); #1;
    chk("adv2_pn", pn_seq_o, EXP2);
    chk("adv2_lfsr", dut.lfsr, 16'h7C41);

    cycle(0, 0, 16'h0);
    cycle(0, 1, 16'h0);
    @(posedge clk_i); #1;
    chk("seed0_lfsr", dut.lfsr, 16'h0001);
    chk("seed0_ack", seed_ack_o, 1);
    cycle(0, 0, 16'h0);
    @(posedge clk_i); #1;
    chk("seed0_ack_pulse", seed_ack_o, 0);
    cycle(1, 0, 16'h0);
    @(posedge clk_i); #1;
    chk("seed0_replay_pn", pn_seq_o, 8'h01);

    cycle(1, 1, 16'hACE1);
    @(posedge clk_i); #1;
    chk("coll_valid", pn_valid_o, 0);
    chk("coll_lfsr", dut.lfsr, 16'hACE1);
    chk("coll_ack", seed_ack_o, 1);
    cycle(0, 0, 16'h0);
    cycle(0, 0, 16'h0);

    @(negedge clk_i);
    enable_i = 1'b0; seed_load_i = 1'b0;
    force dut.lfsr = '0;
    @(posedge clk_i); #1;
    release dut.lfsr;
    chk("lock_flag", lockup_o, 1);
    chk("lock_valid", pn_valid_o, 0);
    @(posedge clk_i); #1;
    chk("recover_lfsr", dut.lfsr, 16'h0001);
    chk("recover_flag", lockup_o, 1);
    m_lfsr = 16'h0001; m_phase = 1'b0; m_in_seed = 1'b0;
    cycle(0, 0, 16'h0);
    @(posedge clk_i); #1;
    chk("lock_sticky", lockup_o, 1);
    cycle(0, 1, 16'h1234);
    @(posedge clk_i); #1;
    chk("lock_cleared", lockup_o, 0);
    cycle(0, 0, 16'h0);

    cycle(1, 0, 16'h0);
    cycle(1, 0, 16'h0);
    @(posedge clk_i); #2 reset_ni = 1'b0;
    #1;
    chk("async_rst_pn", pn_seq_o, 0);
    chk("async_rst_valid", pn_valid_o, 0);
    chk("async_rst_ack", seed_ack_o, 0);
    chk("async_rst_lockup", lockup_o, 0);
    exp_q.delete(); ack_q.delete();
    m_lfsr = 16'h0001; m_phase = 1'b0; m_in_seed = 1'b0;
    @(posedge clk_i); #2 reset_ni = 1'b1;
    model_step(1'b1, 1'b0, 16'h0);
    @(posedge clk_i); #1;
    chk("post_rst_pn", pn_seq_o, 8'h01);
    chk("post_rst_valid", pn_valid_o, 1);

    for (int i = 0; i < 600; i++) begin
      logic        en, ld;
      logic [15:0] sd;
      en = ($urandom_range(0, 9) < 7);
      ld = ($urandom_range(0, 19) == 0);
      sd = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      cycle(en, ld, sd);
    end
    repeat (3) cycle(0, 0, 16'h0);
    @(negedge clk_i);
    chk("pn_queue_drained", exp_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("final_lockup", lockup_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
